// File: rtl/ov7670_config_sequencer_if.sv
// ROM fetch bus and SCCB write-command handshake between the config sequencer
// and its neighbours.
interface ov7670_config_sequencer_if;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        sccb_valid;
    logic        sccb_ready;
    logic [7:0]  sccb_reg;
    logic [7:0]  sccb_dat;
    logic        sccb_done;
    logic        sccb_err;

    modport master (
        output rom_addr,
        input  rom_data,
        output sccb_valid,
        input  sccb_ready,
        output sccb_reg,
        output sccb_dat,
        input  sccb_done,
        input  sccb_err
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  sccb_valid,
        output sccb_ready,
        input  sccb_reg,
        input  sccb_dat,
        output sccb_done,
        output sccb_err
    );
endinterface

// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 config ROM and turns each entry into an SCCB write, a delay or the end.
// Optional macro CFG_RETRY_EN: re-issue a NACKed write up to MAX_RETRY times before giving up.
//
// state     | meaning
// IDLE      | waiting for start (or the automatic start after reset)
// FETCH     | ROM address presented, covering the ROM read latency
// DECODE    | classify rom_data: write, delay marker or end marker
// ISSUE     | sccb_valid held until the SCCB master accepts
// WAIT_DONE | command accepted, waiting for the transaction to finish
// GAP       | idle spacing after a completed write
// DELAY     | timed wait requested by a 0xFFF0 marker
// DONE      | sequence stopped; cfg_done reports success
module ov7670_config_sequencer #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int DELAY_MS    = 10,
    parameter int GAP_CYCLES  = 1000,
    parameter int AUTO_START  = 1,
    parameter int MAX_RETRY   = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    ov7670_config_sequencer_if.master        bus,
    output logic                             busy,
    output logic                             cfg_done,
    output logic                             cfg_error
);

    localparam logic [31:0] DELAY_LOAD = 32'(CLK_FREQ_HZ / 1000 * DELAY_MS - 1);
    localparam logic [31:0] GAP_LOAD   = 32'(GAP_CYCLES - 1);
    localparam logic [15:0] MARK_END   = 16'hFFFF;
    localparam logic [15:0] MARK_DELAY = 16'hFFF0;

    if (GAP_CYCLES < 1 || MAX_RETRY < 0) begin : g_bad_param
        $error("ov7670_config_sequencer: GAP_CYCLES must be >= 1 and MAX_RETRY >= 0");
    end

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, ISSUE, WAIT_DONE, GAP, DELAY, DONE
    } state_t;

    state_t      state;
    logic [31:0] cnt;
    logic        auto_pend;

`ifdef CFG_RETRY_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RW-1:0] retry_cnt;
    logic          retry_pend;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            auto_pend      <= (AUTO_START != 0);
            bus.rom_addr   <= '0;
            bus.sccb_valid <= 1'b0;
            bus.sccb_reg   <= '0;
            bus.sccb_dat   <= '0;
            busy           <= 1'b0;
            cfg_done       <= 1'b0;
            cfg_error      <= 1'b0;
`ifdef CFG_RETRY_EN
            retry_cnt      <= '0;
            retry_pend     <= 1'b0;
`endif
        end else begin
            case (state)
                // auto_pend can only be set in IDLE, so DONE reacts to start alone
                IDLE, DONE: begin
                    if (start || auto_pend) begin
                        auto_pend    <= 1'b0;
                        bus.rom_addr <= '0;
                        busy         <= 1'b1;
                        cfg_done     <= 1'b0;
                        cfg_error    <= 1'b0;
`ifdef CFG_RETRY_EN
                        retry_cnt    <= '0;
                        retry_pend   <= 1'b0;
`endif
                        state        <= FETCH;
                    end
                end

                FETCH: state <= DECODE;

                DECODE: begin
                    if (bus.rom_data == MARK_END) begin
                        busy     <= 1'b0;
                        cfg_done <= 1'b1;
                        state    <= DONE;
                    end else if (bus.rom_data == MARK_DELAY) begin
                        cnt   <= DELAY_LOAD;
                        state <= DELAY;
                    end else begin
                        bus.sccb_reg   <= bus.rom_data[15:8];
                        bus.sccb_dat   <= bus.rom_data[7:0];
                        bus.sccb_valid <= 1'b1;
                        state          <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (bus.sccb_ready) begin
                        bus.sccb_valid <= 1'b0;
                        state          <= WAIT_DONE;
                    end
                end

                WAIT_DONE: begin
                    if (bus.sccb_done) begin
                        cnt   <= GAP_LOAD;
                        state <= GAP;
`ifdef CFG_RETRY_EN
                        if (bus.sccb_err) begin
                            if (retry_cnt == RW'(MAX_RETRY)) begin
                                cfg_error <= 1'b1;
                                busy      <= 1'b0;
                                state     <= DONE;
                            end else begin
                                retry_cnt  <= retry_cnt + 1'b1;
                                retry_pend <= 1'b1;
                            end
                        end else begin
                            retry_cnt <= '0;
                        end
`else
                        if (bus.sccb_err)
                            cfg_error <= 1'b1;
`endif
                    end
                end

                // shared terminal-count handling; address 255 is the last entry, never wrapped
                GAP, DELAY: begin
                    if (cnt == '0) begin
`ifdef CFG_RETRY_EN
                        if (retry_pend) begin
                            retry_pend <= 1'b0;
                            state      <= FETCH;
                        end else
`endif
                        if (bus.rom_addr == 8'hFF) begin
                            busy     <= 1'b0;
                            cfg_done <= 1'b1;
                            state    <= DONE;
                        end else begin
                            bus.rom_addr <= bus.rom_addr + 8'd1;
                            state        <= FETCH;
                        end
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Directed bench for ov7670_config_sequencer: ROM model, SCCB responder and a command scoreboard.
module tb_ov7670_config_sequencer;
    localparam int CLK_FREQ_HZ = 1000;
    localparam int DELAY_MS    = 10;
    localparam int GAP_CYCLES  = 2;
    localparam int MAX_RETRY   = 3;

`ifdef CFG_RETRY_EN
    localparam int NACK_ISSUES = MAX_RETRY + 1;
    localparam int NACK_DONE   = 0;
    localparam int NACK_ADDR   = 2;
`else
    localparam int NACK_ISSUES = 1;
    localparam int NACK_DONE   = 1;
    localparam int NACK_ADDR   = 3;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, cfg_done, cfg_error;

    ov7670_config_sequencer_if bus();

    ov7670_config_sequencer #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .DELAY_MS   (DELAY_MS),
        .GAP_CYCLES (GAP_CYCLES),
        .AUTO_START (1),
        .MAX_RETRY  (MAX_RETRY)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .cfg_done (cfg_done),
        .cfg_error(cfg_error)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [256];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];

    // stimulus knobs, written only by the main initial block
    logic        stall_en = 1'b0;
    logic [15:0] stall_cmd = 16'h0000;
    int          stall_len = 0;
    logic        err_en = 1'b0;
    logic [15:0] err_cmd = 16'h0000;

    // responder state and monotonic statistics, written only by the responder
    int          accept_cnt = 0, stall_cycles = 0, stab_viol = 0, addr1_cycles = 0, gap_act = 0;
    int          stall_left = 0, done_cnt = 0;
    logic        pend_err = 1'b0, prev_valid = 1'b0;
    logic [15:0] hold_cmd = 16'h0000, mcmd;

    always @(negedge clk) begin
        if (!rst_n) begin
            bus.sccb_ready = 1'b1;
            bus.sccb_done  = 1'b0;
            bus.sccb_err   = 1'b0;
            done_cnt   = 0;
            stall_left = 0;
            prev_valid = 1'b0;
        end else begin
            bus.sccb_done = 1'b0;
            bus.sccb_err  = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) begin
                    bus.sccb_done = 1'b1;
                    bus.sccb_err  = pend_err;
                end
            end
            mcmd = {bus.sccb_reg, bus.sccb_dat};
            if (bus.sccb_valid && !prev_valid) begin
                hold_cmd = mcmd;
                if (stall_en && mcmd == stall_cmd) stall_left = stall_len;
            end else if (bus.sccb_valid && mcmd != hold_cmd) begin
                stab_viol++;
            end
            bus.sccb_ready = (stall_left == 0);
            if (stall_left > 0) begin
                stall_left--;
                stall_cycles++;
            end
            if (bus.sccb_valid && bus.sccb_ready) begin
                obs_q.push_back(mcmd);
                accept_cnt++;
                done_cnt = 5;
                pend_err = err_en && (mcmd == err_cmd);
            end
            if (bus.rom_addr == 8'd1 && busy) addr1_cycles++;
            if (bus.rom_addr == 8'd1 && bus.sccb_valid) gap_act++;
            prev_valid = bus.sccb_valid;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_cmds(input string tag);
        logic [15:0] e, o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hxxxx;
            chk({tag, "_cmd"}, {16'h0, o}, {16'h0, e});
        end
        chk({tag, "_extra_cmds"}, obs_q.size(), 0);
        obs_q.delete();
    endtask

    task automatic run_seq(input int budget, input string tag);
        int n;
        n = 0;
        while (!busy && n < 10) begin @(negedge clk); n++; end
        n = 0;
        while (busy && n < budget) begin @(negedge clk); n++; end
        chk({tag, "_finish"}, {31'h0, busy}, 0);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic rom_nominal();
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1214; rom[3] = 16'hFFFF;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int a0, s0, v0, g0, q0, n;
        rom_nominal();

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'h0, bus.sccb_valid}, 0);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_cfg_done", {31'h0, cfg_done}, 0);
        chk("rst_cfg_error", {31'h0, cfg_error}, 0);
        chk("rst_rom_addr", {24'h0, bus.rom_addr}, 0);
        chk("rst_sccb_reg", {24'h0, bus.sccb_reg}, 0);
        chk("rst_sccb_dat", {24'h0, bus.sccb_dat}, 0);

        // nominal run via AUTO_START
        exp_q.push_back(16'h1280); exp_q.push_back(16'h1214);
        a0 = accept_cnt; g0 = addr1_cycles; q0 = gap_act; v0 = stab_viol;
        rst_n = 1'b1;
        run_seq(500, "nom");
        cmp_cmds("nom");
        chk("nom_accepts", accept_cnt - a0, 2);
        chk("nom_cfg_done", {31'h0, cfg_done}, 1);
        chk("nom_cfg_error", {31'h0, cfg_error}, 0);
        chk("nom_rom_addr", {24'h0, bus.rom_addr}, 3);
        chk("nom_addr1_cycles", addr1_cycles - g0, 12);
        chk("nom_delay_activity", gap_act - q0, 0);
        chk("nom_stable", stab_viol - v0, 0);

        // restart from DONE, backpressure on first write, start while busy ignored
        stall_en = 1'b1; stall_cmd = 16'h1280; stall_len = 7;
        exp_q.push_back(16'h1280); exp_q.push_back(16'h1214);
        a0 = accept_cnt; s0 = stall_cycles; v0 = stab_viol;
        pulse_start();
        chk("restart_busy", {31'h0, busy}, 1);
        chk("restart_cfg_done_clr", {31'h0, cfg_done}, 0);
        repeat (6) @(negedge clk);
        pulse_start();
        run_seq(500, "bp");
        stall_en = 1'b0;
        cmp_cmds("bp");
        chk("bp_accepts", accept_cnt - a0, 2);
        chk("bp_stall_cycles", stall_cycles - s0, 7);
        chk("bp_stable", stab_viol - v0, 0);
        chk("bp_rom_addr", {24'h0, bus.rom_addr}, 3);
        chk("bp_cfg_done", {31'h0, cfg_done}, 1);

        // early end marker at address 9
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        for (int i = 0; i < 9; i++) begin
            rom[i] = {8'(i + 1), 8'(8'hA0 + i)};
            exp_q.push_back({8'(i + 1), 8'(8'hA0 + i)});
        end
        a0 = accept_cnt;
        pulse_start();
        run_seq(1000, "early");
        cmp_cmds("early");
        chk("early_accepts", accept_cnt - a0, 9);
        chk("early_rom_addr", {24'h0, bus.rom_addr}, 9);
        chk("early_cfg_done", {31'h0, cfg_done}, 1);

        // no end marker: walk all 256 entries and stop at 255
        for (int i = 0; i < 255; i++) rom[i] = 16'hFFF0;
        rom[255] = 16'hAB55;
        exp_q.push_back(16'hAB55);
        a0 = accept_cnt;
        pulse_start();
        run_seq(6000, "noend");
        cmp_cmds("noend");
        chk("noend_accepts", accept_cnt - a0, 1);
        chk("noend_rom_addr", {24'h0, bus.rom_addr}, 255);
        chk("noend_cfg_done", {31'h0, cfg_done}, 1);
        repeat (5) @(negedge clk);
        chk("noend_no_wrap", {24'h0, bus.rom_addr}, 255);
        chk("noend_idle", {31'h0, busy}, 0);

        // NACK on the write at address 2
        rom_nominal();
        err_en = 1'b1; err_cmd = 16'h1214;
        exp_q.push_back(16'h1280);
        for (int i = 0; i < NACK_ISSUES; i++) exp_q.push_back(16'h1214);
        a0 = accept_cnt;
        pulse_start();
        run_seq(1000, "nack");
        err_en = 1'b0;
        cmp_cmds("nack");
        chk("nack_accepts", accept_cnt - a0, 1 + NACK_ISSUES);
        chk("nack_cfg_error", {31'h0, cfg_error}, 1);
        chk("nack_cfg_done", {31'h0, cfg_done}, NACK_DONE);
        chk("nack_rom_addr", {24'h0, bus.rom_addr}, NACK_ADDR);
        exp_q.push_back(16'h1280); exp_q.push_back(16'h1214);
        pulse_start();
        chk("nack_err_cleared", {31'h0, cfg_error}, 0);
        run_seq(500, "after_nack");
        cmp_cmds("after_nack");
        chk("after_nack_cfg_done", {31'h0, cfg_done}, 1);

        // reset while the write at address 2 is stuck in ISSUE
        stall_en = 1'b1; stall_cmd = 16'h1214; stall_len = 1000;
        exp_q.push_back(16'h1280);
        s0 = stall_cycles;
        pulse_start();
        n = 0;
        while (stall_cycles - s0 < 3 && n < 300) begin @(negedge clk); n++; end
        chk("rstmid_reached_issue", {31'h0, bus.sccb_valid}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_valid_async", {31'h0, bus.sccb_valid}, 0);
        chk("rstmid_busy", {31'h0, busy}, 0);
        stall_en = 1'b0;
        repeat (3) @(negedge clk);
        cmp_cmds("rstmid_before");
        exp_q.push_back(16'h1280); exp_q.push_back(16'h1214);
        a0 = accept_cnt;
        #2 rst_n = 1'b1;
        run_seq(500, "rstmid_after");
        cmp_cmds("rstmid_after");
        chk("rstmid_accepts", accept_cnt - a0, 2);
        chk("rstmid_cfg_done", {31'h0, cfg_done}, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ov7670_config_sequencer.md
Name: ov7670_config_sequencer

Overview:
- Reads the OV7670 configuration ROM one entry at a time.
- Decodes each 16-bit entry as a register write, a delay marker (0xFFF0) or the end marker (0xFFFF).
- Sends each register write to the SCCB master through a valid/ready command port, then waits for completion.
- Sits between the config ROM and the SCCB master in the camera subsystem. Asserts cfg_done when the camera is ready for capture.

Parameters:
- CLK_FREQ_HZ, 100_000_000, clk frequency; sets the delay-marker duration.
- DELAY_MS, 10, wait time for each 0xFFF0 marker, in ms.
- GAP_CYCLES, 1000, idle clk cycles after each completed write, before the next ROM fetch (minimum 1).
- AUTO_START, 1, 1 = start the sequence automatically on the first clk after reset deasserts.
- MAX_RETRY, 3, retry limit per entry (used only with CFG_RETRY_EN).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; starts or restarts the sequence from address 0
- rom_addr  out  8  ROM address
- rom_data  in  16  ROM data; registered, valid one clk after rom_addr is sampled
- sccb_valid  out  1  write command valid
- sccb_ready  in  1  SCCB master accepts the command
- sccb_reg  out  8  register address, rom_data[15:8]
- sccb_dat  out  8  register value, rom_data[7:0]
- sccb_done  in  1  one-cycle pulse; the transaction has finished
- sccb_err  in  1  NACK status; sampled only when sccb_done=1
- busy  out  1  high while a sequence is running
- cfg_done  out  1  high after the end marker; sticky until the next start or reset
- cfg_error  out  1  sticky error flag; cleared on start

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rom_addr=0; sccb_valid=0; sccb_reg=0; sccb_dat=0.
  - busy=0; cfg_done=0; cfg_error=0; all counters cleared.
  - Reset mid-transaction drops sccb_valid immediately. After reset the sequence restarts from 0.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT_DONE, GAP, DELAY, DONE.
- IDLE -> FETCH:
  - on start=1, or on the first cycle after reset when AUTO_START=1.
  - Sets rom_addr=0, busy=1, cfg_done=0, cfg_error=0.
- FETCH: one wait cycle to cover ROM latency; then -> DECODE.
- DECODE: rom_data is sampled exactly 2 clk edges after rom_addr changed.
  - 0xFFFF -> DONE.
  - 0xFFF0 -> DELAY; load counter = CLK_FREQ_HZ/1000*DELAY_MS - 1 (32-bit, computed at elaboration).
  - Any other value -> ISSUE; latch sccb_reg/sccb_dat and set sccb_valid=1.
- ISSUE:
  - Holds sccb_valid, sccb_reg and sccb_dat stable until a cycle with sccb_ready=1.
  - In that cycle the command transfers; sccb_valid=0 on the next cycle; -> WAIT_DONE.
- WAIT_DONE:
  - Waits for sccb_done=1. A sccb_done pulse seen in any other state is ignored.
  - On sccb_err=1, error handling applies (see Optional Feature).
  - Then -> GAP with counter = GAP_CYCLES-1.
- GAP / DELAY:
  - Decrement the counter to 0.
  - At 0: rom_addr += 1, then -> FETCH.
  - Exception: if rom_addr==255, go -> DONE instead. rom_addr never wraps.
- DONE:
  - busy=0, cfg_done=1, sccb_valid=0.
  - start=1 here goes -> FETCH and restarts from address 0.
- start while busy=1 is ignored.
- start in the same cycle as reset deassertion: the reset takes priority, then AUTO_START rules apply.
- A delay marker issues no SCCB command.
- Consecutive delay markers are each honoured in full.

Optional Feature:
- Macro: CFG_RETRY_EN.
- Defined:
  - On sccb_done with sccb_err=1, re-issue the same entry after GAP, without incrementing rom_addr.
  - Retry up to MAX_RETRY times (counter width $clog2(MAX_RETRY+1)).
  - When retries are exhausted: set cfg_error=1, stop without advancing, -> DONE with cfg_done=0.
  - The retry counter clears on each successful write.
- Not defined:
  - sccb_err=1 sets cfg_error=1 and the sequence advances normally; it still reaches cfg_done=1.
  - No retry logic is synthesised.

Test Plan:
- Nominal sequence:
  - Stimulus: CLK_FREQ_HZ=1000, DELAY_MS=10, GAP_CYCLES=2; ROM {0x1280, 0xFFF0, 0x1214, 0xFFFF}; model with sccb_ready=1 and done 5 clk after accept.
  - Required: exactly 2 commands, (0x12,0x80) then (0x12,0x14).
  - Required: 10 clk of no activity between the first write's GAP and the fetch of address 2.
  - Required: cfg_done=1 and busy=0 after address 3.
- Backpressure:
  - Stimulus: hold sccb_ready=0 for 7 clk.
  - Required: sccb_valid, sccb_reg and sccb_dat stay stable for all 7 clk; exactly one transfer; no duplicate command.
- Early end and boundary:
  - Stimulus: ROM returns 0xFFFF at address 9.
  - Required: stop with rom_addr=9 and 9 writes issued.
  - Stimulus: ROM with no end marker.
  - Required: stop after address 255 with no wrap to 0.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during ISSUE.
  - Required: sccb_valid=0 asynchronously; after release with AUTO_START=1, the first command issued is from address 0.
- Restart and ignored start:
  - Stimulus: start pulse while busy.
  - Required: no effect.
  - Stimulus: start pulse in DONE.
  - Required: cfg_done clears and the full sequence is repeated.
- NACK handling:
  - Stimulus: sccb_err=1 on the write at address 2.
  - Required with CFG_RETRY_EN and MAX_RETRY=3: (0x12,0x14) issued 4 times, then cfg_error=1 and cfg_done=0.
  - Required without the macro: issued once, cfg_error=1, and the sequence completes with cfg_done=1.
